// File: rtl/rng_sched.sv
// Round-robin burst scheduler that streams bytes from an 8-bit Fibonacci LFSR to the granted requester.
// A granted burst runs to completion. The LFSR advances once per accepted beat.
module rng_sched #(
  parameter int N_REQ = 4,
  parameter int LEN_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*LEN_W-1:0] i_len,
  input  logic                   i_seed_we,
  input  logic [7:0]             i_seed,
  input  logic                   i_ready,
  output logic [N_REQ-1:0]       o_gnt,
  output logic                   o_valid,
  output logic [7:0]             o_data,
  output logic                   o_last,
  output logic                   o_busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = LEN_W + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state_reg, state_next;
  logic [7:0]       lfsr_reg, lfsr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [N_REQ-1:0] gnt_reg, gnt_next;
  logic [IDX_W-1:0] last_reg, last_next;

  logic [LEN_W-1:0] len_arr [N_REQ];
  logic [LEN_W-1:0] sel_len;
  logic [IDX_W-1:0] sel_idx;
  logic             found;
  logic             handshake;
  logic             lfsr_fb;
  int               cand;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_len
      assign len_arr[gi] = i_len[gi*LEN_W +: LEN_W];
    end
  endgenerate

  // Search starts one past the last granted requester, so the previous winner goes last
  always_comb begin
    found   = 1'b0;
    sel_idx = last_reg;
    cand    = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = (int'(last_reg) + i) % N_REQ;
      if (!found && i_req[cand]) begin
        found   = 1'b1;
        sel_idx = IDX_W'(cand);
      end
    end
  end

  assign sel_len   = len_arr[sel_idx];
  assign handshake = (state_reg == BURST) && i_ready;
  assign lfsr_fb   = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];

  always_comb begin
    state_next = state_reg;
    lfsr_next  = lfsr_reg;
    cnt_next   = cnt_reg;
    gnt_next   = gnt_reg;
    last_next  = last_reg;
    case (state_reg)
      IDLE: begin
        // A zero seed would lock the LFSR at zero
        if (i_seed_we)
          lfsr_next = (i_seed == 8'h00) ? 8'h01 : i_seed;
        if (found) begin
          state_next = BURST;
          gnt_next   = N_REQ'(1) << sel_idx;
          last_next  = sel_idx;
          cnt_next   = (sel_len == '0) ? (CNT_W'(1) << LEN_W) : {1'b0, sel_len};
        end
      end
      BURST: begin
        if (handshake) begin
          lfsr_next = {lfsr_reg[6:0], lfsr_fb};
          cnt_next  = cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            state_next = IDLE;
            gnt_next   = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      lfsr_reg  <= 8'h01;
      cnt_reg   <= '0;
      gnt_reg   <= '0;
      last_reg  <= IDX_W'(N_REQ - 1);
    end else begin
      state_reg <= state_next;
      lfsr_reg  <= lfsr_next;
      cnt_reg   <= cnt_next;
      gnt_reg   <= gnt_next;
      last_reg  <= last_next;
    end
  end

  assign o_busy  = (state_reg == BURST);
  assign o_valid = o_busy;
  assign o_last  = o_busy && (cnt_reg == CNT_W'(1));
  assign o_data  = lfsr_reg;
  assign o_gnt   = gnt_reg;

endmodule

// File: tb/tb_rng_sched.sv
// Directed bench for rng_sched: reset, bursts, round-robin order, stalls, seeding and mid-burst reset.
module tb_rng_sched;

  localparam int N_REQ = 4;
  localparam int LEN_W = 4;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [N_REQ-1:0]       i_req = '0;
  logic [N_REQ*LEN_W-1:0] i_len = '0;
  logic                   i_seed_we = 1'b0;
  logic [7:0]             i_seed = '0;
  logic                   i_ready = 1'b0;
  logic [N_REQ-1:0]       o_gnt;
  logic                   o_valid;
  logic [7:0]             o_data;
  logic                   o_last;
  logic                   o_busy;

  int checks = 0;
  int errors = 0;

  rng_sched #(.N_REQ(N_REQ), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_len     (i_len),
    .i_seed_we (i_seed_we),
    .i_seed    (i_seed),
    .i_ready   (i_ready),
    .o_gnt     (o_gnt),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_last    (o_last),
    .o_busy    (o_busy)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    i_req = '0;
    i_seed_we = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_gnt, o_valid, o_last, o_busy} !== 7'b0 || o_data !== 8'h01) begin
      errors++;
      $display("FAIL reset_state: gnt=%b valid=%b last=%b busy=%b data=%02h, required 0000 0 0 0 01",
               o_gnt, o_valid, o_last, o_busy, o_data);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (o_busy !== 1'b0 || o_data !== 8'h01) begin
      errors++;
      $display("FAIL reset_idle_no_req: busy=%b data=%02h, required 0 01", o_busy, o_data);
    end
    $display("reset: gnt=%b data=%02h", o_gnt, o_data);
  endtask

  task automatic test_basic(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                            input logic [7:0] e_idle);
    logic [7:0] exp_data [3];
    exp_data = '{e0, e1, e2};
    i_req = 4'b0001;
    i_len = 16'h0003;
    i_ready = 1'b1;
    tick();
    i_req = '0;
    for (int i = 0; i < 3; i++) begin
      $display("beat: gnt=%b data=%02h last=%b", o_gnt, o_data, o_last);
      checks++;
      if (o_gnt !== 4'b0001 || o_valid !== 1'b1 || o_busy !== 1'b1 ||
          o_data !== exp_data[i] || o_last !== (i == 2)) begin
        errors++;
        $display("FAIL basic_beat%0d: gnt=%b valid=%b data=%02h last=%b, required 0001 1 %02h %b",
                 i, o_gnt, o_valid, o_data, o_last, exp_data[i], (i == 2));
      end
      tick();
    end
    checks++;
    if (o_valid !== 1'b0 || o_gnt !== 4'b0 || o_busy !== 1'b0 || o_data !== e_idle) begin
      errors++;
      $display("FAIL basic_idle: valid=%b gnt=%b busy=%b data=%02h, required 0 0000 0 %02h",
               o_valid, o_gnt, o_busy, o_data, e_idle);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_gnt [5];
    logic [7:0] exp_data [5];
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_data = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    do_reset();
    i_req = 4'b1111;
    i_len = 16'h1111;
    i_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      $display("rr burst %0d: gnt=%b data=%02h last=%b", k, o_gnt, o_data, o_last);
      checks++;
      if (o_gnt !== exp_gnt[k] || o_valid !== 1'b1 || o_data !== exp_data[k] || o_last !== 1'b1) begin
        errors++;
        $display("FAIL rr_grant%0d: gnt=%b valid=%b data=%02h last=%b, required %b 1 %02h 1",
                 k, o_gnt, o_valid, o_data, o_last, exp_gnt[k], exp_data[k]);
      end
      if (k == 4) i_req = '0;
      tick();
      checks++;
      if (o_valid !== 1'b0 || o_gnt !== 4'b0) begin
        errors++;
        $display("FAIL rr_gap%0d: valid=%b gnt=%b, required 0 0000", k, o_valid, o_gnt);
      end
    end
  endtask

  task automatic test_stall;
    do_reset();
    i_req = 4'b0001;
    i_len = 16'h0003;
    i_ready = 1'b0;
    tick();
    i_req = '0;
    i_len = 16'h0001;
    for (int c = 0; c < 3; c++) begin
      $display("stall cycle %0d: data=%02h valid=%b ready=%b", c, o_data, o_valid, i_ready);
      checks++;
      if (o_valid !== 1'b1 || o_data !== 8'h01 || o_last !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: valid=%b data=%02h last=%b, required 1 01 0",
                 c, o_valid, o_data, o_last);
      end
      if (c == 2) i_ready = 1'b1;
      tick();
    end
    checks++;
    if (o_data !== 8'h02 || o_last !== 1'b0 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_beat1: data=%02h last=%b valid=%b, required 02 0 1", o_data, o_last, o_valid);
    end
    tick();
    checks++;
    if (o_data !== 8'h04 || o_last !== 1'b1) begin
      errors++;
      $display("FAIL stall_beat2: data=%02h last=%b, required 04 1", o_data, o_last);
    end
    tick();
    checks++;
    if (o_valid !== 1'b0 || o_data !== 8'h08) begin
      errors++;
      $display("FAIL stall_idle: valid=%b data=%02h, required 0 08", o_valid, o_data);
    end
  endtask

  task automatic test_seed;
    // Zero seed loaded together with a grant: first beat must be 0x01
    i_seed_we = 1'b1;
    i_seed = 8'h00;
    i_req = 4'b0001;
    i_len = 16'h0001;
    i_ready = 1'b1;
    tick();
    i_req = '0;
    i_seed = 8'hA5;
    $display("seed zero: data=%02h last=%b", o_data, o_last);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h01 || o_last !== 1'b1) begin
      errors++;
      $display("FAIL seed_zero: valid=%b data=%02h last=%b, required 1 01 1", o_valid, o_data, o_last);
    end
    tick();
    i_seed_we = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_data !== 8'h02) begin
      errors++;
      $display("FAIL seed_ignored_in_burst: valid=%b data=%02h, required 0 02", o_valid, o_data);
    end
    i_seed_we = 1'b1;
    i_seed = 8'h08;
    i_req = 4'b0001;
    i_len = 16'h0002;
    tick();
    i_seed_we = 1'b0;
    i_req = '0;
    $display("seed 08: data=%02h last=%b", o_data, o_last);
    checks++;
    if (o_data !== 8'h08 || o_last !== 1'b0) begin
      errors++;
      $display("FAIL seed_with_grant: data=%02h last=%b, required 08 0", o_data, o_last);
    end
    tick();
    checks++;
    if (o_data !== 8'h11 || o_last !== 1'b1) begin
      errors++;
      $display("FAIL seed_next: data=%02h last=%b, required 11 1", o_data, o_last);
    end
    tick();
  endtask

  task automatic test_reset_mid_burst;
    i_req = 4'b0010;
    i_len = 16'h0030;
    i_ready = 1'b1;
    tick();
    checks++;
    if (o_gnt !== 4'b0010 || o_data !== 8'h23) begin
      errors++;
      $display("FAIL midrst_start: gnt=%b data=%02h, required 0010 23", o_gnt, o_data);
    end
    tick();
    #2 rst_n = 1'b0;
    #1;
    $display("mid-burst reset: gnt=%b valid=%b data=%02h", o_gnt, o_valid, o_data);
    checks++;
    if ({o_gnt, o_valid, o_last, o_busy} !== 7'b0 || o_data !== 8'h01) begin
      errors++;
      $display("FAIL midrst_outputs: gnt=%b valid=%b last=%b busy=%b data=%02h, required 0000 0 0 0 01",
               o_gnt, o_valid, o_last, o_busy, o_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    i_req = 4'b1111;
    i_len = 16'h1111;
    tick();
    i_req = '0;
    checks++;
    if (o_gnt !== 4'b0001 || o_data !== 8'h01) begin
      errors++;
      $display("FAIL midrst_first_grant: gnt=%b data=%02h, required 0001 01", o_gnt, o_data);
    end
    tick();
  endtask

  task automatic test_len_zero;
    int beats;
    int last_at;
    beats = 0;
    last_at = -1;
    i_req = 4'b0100;
    i_len = 16'h0000;
    i_ready = 1'b1;
    tick();
    i_req = '0;
    checks++;
    if (o_gnt !== 4'b0100) begin
      errors++;
      $display("FAIL len0_grant: gnt=%b, required 0100", o_gnt);
    end
    for (int c = 0; c < 40 && o_valid; c++) begin
      if (o_last) last_at = beats;
      beats++;
      tick();
    end
    $display("len0 burst: beats=%0d last_at=%0d", beats, last_at);
    checks++;
    if (beats != 16 || last_at != 15) begin
      errors++;
      $display("FAIL len0_beats: beats=%0d last_at=%0d, required 16 15", beats, last_at);
    end
  endtask

  initial begin
    test_reset();
    test_basic(8'h01, 8'h02, 8'h04, 8'h08);
    test_basic(8'h08, 8'h11, 8'h23, 8'h47);
    test_round_robin();
    test_stall();
    test_seed();
    test_reset_mid_burst();
    test_len_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rng_sched.md
RNG_SCHED -- requirements
Module: rng_sched

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter LEN_W, default 4, width of per-requester burst-length field.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_req  input  N_REQ  per-requester burst request, level.
REQ-006 i_len  input  N_REQ*LEN_W  per-requester burst length, slice k = bits [k*LEN_W +: LEN_W].
REQ-007 i_seed_we  input  1  seed load strobe.
REQ-008 i_seed  input  8  seed value.
REQ-009 o_gnt  output  N_REQ  one-hot grant, held for the whole burst.
REQ-010 o_valid  output  1  o_data holds a valid beat.
REQ-011 o_data  output  8  pseudo-random byte (current generator state).
REQ-012 o_last  output  1  current beat is the final beat of the burst.
REQ-013 i_ready  input  1  granted consumer accepts the beat.
REQ-014 o_busy  output  1  burst in progress (state BURST).

Function
REQ-015 The block SHALL contain an 8-bit Fibonacci generator, polynomial x^8+x^6+x^5+x^4+1, next = {s[6:0], s[7]^s[5]^s[4]^s[3]}.
REQ-016 Generator SHALL advance only on a handshake (o_valid & i_ready), once per handshake.
REQ-017 FSM SHALL have two states: IDLE and BURST.
REQ-018 In IDLE with any i_req bit set, the block SHALL select one requester round-robin: search starts at index (last granted + 1) mod N_REQ, wrapping.
REQ-019 On selection: go to BURST next cycle; o_gnt one-hot for selected index; latch its i_len; update last-granted pointer.
REQ-020 Latched length 0 SHALL mean 2^LEN_W beats; any other value L means L beats.
REQ-021 In BURST, o_valid SHALL be 1 every cycle; o_data = generator state; o_last = 1 when remaining count is 1.
REQ-022 Each handshake SHALL decrement the remaining count; the handshake with o_last=1 returns FSM to IDLE and clears o_gnt and o_valid next cycle.
REQ-023 i_ready low in BURST SHALL stall: o_data, o_last, count, generator unchanged.
REQ-024 i_req and i_len changes during BURST SHALL be ignored; deasserting i_req does not abort the burst.
REQ-025 At least one IDLE cycle SHALL separate consecutive bursts; grant-to-first-beat latency is 1 cycle.
REQ-026 i_seed_we SHALL load i_seed into the generator only in IDLE; in BURST it is ignored.
REQ-027 A loaded seed of 0x00 SHALL be replaced by 0x01 (lock-up avoidance).
REQ-028 If i_seed_we and a grant decision occur in the same IDLE cycle, both SHALL take effect; the first beat uses the new seed.
REQ-029 In IDLE: o_valid=0, o_last=0, o_gnt=0, o_busy=0; o_data still shows generator state.

Reset
REQ-030 On rst_n low: state IDLE, generator 0x01, o_gnt 0, o_valid 0, o_last 0, o_busy 0, remaining count 0, last-granted pointer N_REQ-1 (so requester 0 has first priority).
REQ-031 Reset asserted mid-burst SHALL abort immediately; no beat is completed.
REQ-032 After reset deassertion, first grant no earlier than the first rising edge with rst_n high.

Verification
REQ-033 After reset, i_req=0001, len0=3, i_ready=1 -> o_gnt=0001, beats 0x01,0x02,0x04, o_last on 0x04, then IDLE.
REQ-034 Repeat REQ-033 request -> beats 0x08,0x11,0x23 (generator continues).
REQ-035 i_req=1111 held, all len=1 -> grant order 0,1,2,3,0 with one IDLE cycle between bursts.
REQ-036 Burst of 3, i_ready low 2 cycles after first beat -> 0x01 held valid 3 cycles, sequence unchanged, no skipped value.
REQ-037 Seed load 0x00 in IDLE, then burst len=1 -> data 0x01; seed 0xA5 attempted during BURST -> ignored.
REQ-038 rst_n pulsed low mid-burst -> outputs zero immediately, generator 0x01, next grant goes to requester 0.
